// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART state encodings, limits and config clamps
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP1     = 3'd4,
    ST_STOP2     = 3'd5,
    ST_WAIT_IDLE = 3'd6
  } uart_state_e;

  localparam int unsigned MIN_BITS    = 5;
  localparam int unsigned MAX_BITS    = 16;
  localparam int unsigned MIN_CLK_DIV = 4;

  // Bit periods shorter than MIN_CLK_DIV leave no room for a mid-bit sample.
  function automatic logic [15:0] clamp_clk_div(input logic [15:0] div);
    return (div < 16'(MIN_CLK_DIV)) ? 16'(MIN_CLK_DIV) : div;
  endfunction

  function automatic logic [4:0] clamp_bits(input logic [4:0] bits);
    if (bits < 5'(MIN_BITS)) return 5'(MIN_BITS);
    if (bits > 5'(MAX_BITS)) return 5'(MAX_BITS);
    return bits;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial line, frame config and received-word bundle
interface uart_rx_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  rx;
  logic [15:0]           clk_div;
  logic [4:0]            bits_per_word;
  logic                  parity_en;
  logic                  parity_evan_odd;
  logic                  two_stop_bit;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid;
  logic                  busy;
  logic                  parity_err;
  logic                  frame_err;

  modport master (
    output rx, clk_div, bits_per_word, parity_en, parity_evan_odd, two_stop_bit,
    input  data_out, valid, busy, parity_err, frame_err
  );

  modport slave (
    input  rx, clk_div, bits_per_word, parity_en, parity_evan_odd, two_stop_bit,
    output data_out, valid, busy, parity_err, frame_err
  );
endinterface

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop rx synchronizer with falling-edge detect
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_rx,
  output logic o_rx,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Resynchronize the idle-high line and keep one cycle of history for the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_rx;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rx   = r_sync;
  assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - configurable UART receiver: FSM, baud counter, word capture
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  logic                  w_rx;
  logic                  w_fall;
  uart_state_e           r_state;
  uart_state_e           w_state_next;
  logic [15:0]           r_cnt;
  logic [15:0]           r_div;
  logic [15:0]           w_target;
  logic [4:0]            r_bits;
  logic [4:0]            r_bitcnt;
  logic                  r_par_en;
  logic                  r_par_odd;
  logic                  r_two_stop;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_acc;
  logic                  r_perr_acc;
  logic                  r_ferr_acc;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_valid;
  logic                  r_parity_err;
  logic                  r_frame_err;
  logic                  w_counting;
  logic                  w_sample;
  logic                  w_last_bit;
  logic                  w_final_stop;
  logic                  w_start_det;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .i_rx   (bus.rx),
    .o_rx   (w_rx),
    .o_fall (w_fall)
  );

  // START samples at half a bit so every later sample lands mid-bit.
  assign w_target     = (r_state == ST_START) ? {1'b0, r_div[15:1]} : r_div;
  assign w_counting   = (r_state != ST_IDLE) && (r_state != ST_WAIT_IDLE);
  assign w_sample     = w_counting && (r_cnt == w_target);
  assign w_last_bit   = (r_bitcnt == (r_bits - 5'd1));
  assign w_final_stop = w_sample &&
                        ((r_state == ST_STOP2) || ((r_state == ST_STOP1) && !r_two_stop));
  assign w_start_det  = (r_state == ST_IDLE) && w_fall;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; every transition out of a bit state happens on its sample.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) w_state_next = ST_START;
      end
      ST_START: begin
        if (w_sample) w_state_next = w_rx ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (w_sample && w_last_bit) w_state_next = r_par_en ? ST_PARITY : ST_STOP1;
      end
      ST_PARITY: begin
        if (w_sample) w_state_next = ST_STOP1;
      end
      ST_STOP1: begin
        if (w_sample) begin
          if (r_two_stop) w_state_next = ST_STOP2;
          else            w_state_next = w_rx ? ST_IDLE : ST_WAIT_IDLE;
        end
      end
      ST_STOP2: begin
        if (w_sample) w_state_next = w_rx ? ST_IDLE : ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (w_rx) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Baud counter: restarts at 1 on entry to a bit state and after each sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= 16'd0;
    end else if ((w_state_next == ST_IDLE) || (w_state_next == ST_WAIT_IDLE)) begin
      r_cnt <= 16'd0;
    end else if (w_sample || (w_state_next != r_state)) begin
      r_cnt <= 16'd1;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  // Latch frame config at the start edge and accumulate data, parity and stop errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div      <= 16'd0;
      r_bits     <= 5'd0;
      r_par_en   <= 1'b0;
      r_par_odd  <= 1'b0;
      r_two_stop <= 1'b0;
      r_bitcnt   <= 5'd0;
      r_shift    <= '0;
      r_par_acc  <= 1'b0;
      r_perr_acc <= 1'b0;
      r_ferr_acc <= 1'b0;
    end else if (w_start_det) begin
      r_div      <= clamp_clk_div(bus.clk_div);
      r_bits     <= clamp_bits(bus.bits_per_word);
      r_par_en   <= bus.parity_en;
      r_par_odd  <= bus.parity_evan_odd;
      r_two_stop <= bus.two_stop_bit;
      r_bitcnt   <= 5'd0;
      r_shift    <= '0;
      r_par_acc  <= 1'b0;
      r_perr_acc <= 1'b0;
      r_ferr_acc <= 1'b0;
    end else if (w_sample) begin
      case (r_state)
        ST_DATA: begin
          r_shift   <= r_shift | (DATA_WIDTH'(w_rx) << r_bitcnt);
          r_par_acc <= r_par_acc ^ w_rx;
          r_bitcnt  <= r_bitcnt + 5'd1;
        end
        ST_PARITY: begin
          r_perr_acc <= r_par_acc ^ w_rx ^ r_par_odd;
        end
        ST_STOP1: begin
          if (!w_rx) r_ferr_acc <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Present the word and its flags together with a one-cycle valid after the last stop sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_data_out   <= '0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_valid <= w_final_stop;
      if (w_final_stop) begin
        r_data_out   <= r_shift;
        r_parity_err <= r_perr_acc;
        r_frame_err  <= r_ferr_acc | ~w_rx;
      end
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.valid      = r_valid;
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.parity_err = r_parity_err;
  assign bus.frame_err  = r_frame_err;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;

  typedef struct {
    int         div_cfg;
    int         bits_cfg;
    bit         pen;
    bit         podd;
    bit         two;
    logic [15:0] data;
    bit         bad_par;
    bit         bad_stop;
  } vec_t;

  typedef struct {
    logic [15:0] data;
    logic        perr;
    logic        ferr;
    int          t_valid;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_valid = 0;
  int   n_exp = 0;
  int   busy_cnt = 0;
  logic prev_valid = 1'b0;
  exp_t sb[$];
  exp_t e_mon;
  vec_t vecs[10];

  uart_rx_if #(.DATA_WIDTH(16)) bus ();

  uart_rx #(.DATA_WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int eff_div(input int c);
    return (c < 4) ? 4 : c;
  endfunction

  function automatic int eff_bits(input int c);
    if (c < 5)  return 5;
    if (c > 16) return 16;
    return c;
  endfunction

  // Monitor: pops the scoreboard on every valid and checks word, flags and timing.
  always @(negedge clk) begin
    if (bus.busy) busy_cnt++;
    if (bus.valid) begin
      n_valid++;
      chk("valid_one_cycle", 32'(prev_valid), 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=1 required=0 data=%0h (cycle %0d)", bus.data_out, cyc);
      end else begin
        e_mon = sb.pop_front();
        chk("data_out",   32'(bus.data_out),   32'(e_mon.data));
        chk("parity_err", 32'(bus.parity_err), 32'(e_mon.perr));
        chk("frame_err",  32'(bus.frame_err),  32'(e_mon.ferr));
        chk("valid_cycle", 32'(cyc),           32'(e_mon.t_valid));
      end
    end
    prev_valid = bus.valid;
  end

  task automatic drive_bit(input logic b, input int n);
    bus.rx = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame and pushes its expected result; called just after a clock edge.
  task automatic send_frame(input int div_cfg, input int bits_cfg, input bit pen, input bit podd,
                            input bit two, input logic [15:0] data, input bit bad_par,
                            input bit bad_stop, input int gap);
    int          div;
    int          nb;
    int          k;
    logic [15:0] m;
    logic        p;
    exp_t        e;
    div = eff_div(div_cfg);
    nb  = eff_bits(bits_cfg);
    m   = '0;
    for (int i = 0; i < nb; i++) m[i] = data[i];
    p = (^m) ^ podd ^ bad_par;
    k = nb + (pen ? 1 : 0) + (two ? 2 : 1);
    bus.clk_div         = 16'(div_cfg);
    bus.bits_per_word   = 5'(bits_cfg);
    bus.parity_en       = pen;
    bus.parity_evan_odd = podd;
    bus.two_stop_bit    = two;
    e.data    = m;
    e.perr    = pen & bad_par;
    e.ferr    = bad_stop;
    e.t_valid = cyc + 3 + div / 2 + k * div;
    sb.push_back(e);
    n_exp++;
    busy_cnt = 0;
    drive_bit(1'b0, div);
    for (int i = 0; i < nb; i++) drive_bit(m[i], div);
    if (pen) drive_bit(p, div);
    drive_bit(!bad_stop, div);
    if (two) drive_bit(!bad_stop, div);
    if (gap > 0) drive_bit(1'b1, gap);
  endtask

  task automatic wait_drain(input int bound);
    for (int k = 0; k < bound && sb.size() != 0; k++) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int v_before;
    exp_t e;

    vecs[0] = '{8,  8,  0, 0, 0, 16'h0055, 0, 0};
    vecs[1] = '{8,  7,  1, 0, 0, 16'h0041, 1, 0};
    vecs[2] = '{8,  16, 1, 1, 1, 16'hA5C3, 0, 0};
    vecs[3] = '{6,  5,  0, 0, 0, 16'h00F5, 0, 0};
    vecs[4] = '{2,  8,  1, 1, 0, 16'h00C9, 0, 0};
    vecs[5] = '{7,  3,  0, 0, 1, 16'h001A, 0, 0};
    vecs[6] = '{5,  20, 1, 0, 0, 16'hFFFF, 0, 0};
    vecs[7] = '{9,  8,  1, 1, 0, 16'h0033, 1, 0};
    vecs[8] = '{8,  8,  0, 0, 0, 16'h00A7, 0, 1};
    vecs[9] = '{11, 6,  1, 0, 1, 16'h002D, 0, 0};

    bus.rx = 1'b1;
    bus.clk_div = 16'd8;
    bus.bits_per_word = 5'd8;
    bus.parity_en = 1'b0;
    bus.parity_evan_odd = 1'b0;
    bus.two_stop_bit = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",       32'(bus.busy),       32'd0);
    chk("rst_valid",      32'(bus.valid),      32'd0);
    chk("rst_data_out",   32'(bus.data_out),   32'd0);
    chk("rst_parity_err", 32'(bus.parity_err), 32'd0);
    chk("rst_frame_err",  32'(bus.frame_err),  32'd0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Table-driven frames: word, flags and valid timing via the monitor, busy span here.
    for (int i = 0; i < 10; i++) begin
      int d;
      int nb;
      int k;
      d  = eff_div(vecs[i].div_cfg);
      nb = eff_bits(vecs[i].bits_cfg);
      k  = nb + (vecs[i].pen ? 1 : 0) + (vecs[i].two ? 2 : 1);
      send_frame(vecs[i].div_cfg, vecs[i].bits_cfg, vecs[i].pen, vecs[i].podd, vecs[i].two,
                 vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop, 3 * d);
      wait_drain(200);
      if (!vecs[i].bad_stop) chk($sformatf("busy_span_%0d", i), 32'(busy_cnt), 32'(d / 2 + k * d));
      chk($sformatf("idle_after_%0d", i), 32'(bus.busy), 32'd0);
    end

    // Short glitch is a false start: busy briefly, then idle, no word.
    bus.clk_div = 16'd16;
    bus.bits_per_word = 5'd8;
    bus.parity_en = 1'b0;
    bus.two_stop_bit = 1'b0;
    v_before = n_valid;
    drive_bit(1'b0, 2);
    drive_bit(1'b1, 3);
    chk("glitch_busy", 32'(bus.busy), 32'd1);
    drive_bit(1'b1, 20);
    chk("glitch_idle", 32'(bus.busy), 32'd0);
    chk("glitch_no_valid", 32'(n_valid), 32'(v_before));

    // Break: one all-zero word with frame error, then hold in WAIT_IDLE until rx rises.
    e.data = 16'h0000;
    e.perr = 1'b0;
    e.ferr = 1'b1;
    e.t_valid = cyc + 3 + 8 + 9 * 16;
    sb.push_back(e);
    n_exp++;
    v_before = n_valid;
    drive_bit(1'b0, 320);
    chk("break_one_valid", 32'(n_valid), 32'(v_before + 1));
    chk("break_wait_busy", 32'(bus.busy), 32'd1);
    drive_bit(1'b1, 8);
    chk("break_rearm_idle", 32'(bus.busy), 32'd0);
    chk("break_no_more_valid", 32'(n_valid), 32'(v_before + 1));

    // Reset in the middle of DATA aborts the frame on the next cycle.
    bus.clk_div = 16'd8;
    drive_bit(1'b0, 8);
    drive_bit(1'b1, 12);
    chk("mid_data_busy", 32'(bus.busy), 32'd1);
    v_before = n_valid;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_busy",  32'(bus.busy),  32'd0);
    chk("abort_valid", 32'(bus.valid), 32'd0);
    rst = 1'b0;
    drive_bit(1'b1, 16);
    chk("abort_no_valid", 32'(n_valid), 32'(v_before));
    send_frame(8, 8, 0, 0, 0, 16'h003C, 0, 0, 16);
    wait_drain(200);

    // Back-to-back frames with an odd bit period and no idle gap.
    send_frame(5, 8, 0, 0, 0, 16'h0001, 0, 0, 0);
    send_frame(5, 8, 0, 0, 0, 16'h00FF, 0, 0, 10);
    wait_drain(200);

    drive_bit(1'b1, 20);
    chk("total_valids", 32'(n_valid), 32'(n_exp));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
